sap1_loader: RTL and testbench

SAP1_LOADER -- requirements
Module: sap1_loader

---
 rtl/sap1_loader.sv | 264 ++++++++++++++++++++++++++
 tb/tb_sap1_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap1_loader.sv
// ---------------------------------------------------------------------------
// sap1_loader
//
// Byte-stream program loader for a SAP-1 style CPU. A frame is:
//     SYNC_BYTE, N, data[0] .. data[N-1] [, checksum]
// Each data byte is written to RAM address 0..N-1. The CPU is held in reset
// until a complete frame has been accepted, then released (DONE). A reload
// pulse in DONE re-arms the loader for a new frame.
//
// Build option:
//     LOADER_CHECKSUM_EN  defined   -> a trailing checksum byte (8-bit sum of
//                                      the data bytes) is expected and checked
//                                      in the CHECK state.
//                         undefined -> no checksum byte; the last data byte
//                                      completes the frame.
//
// Ports:
//     clk        in   system clock, rising edge
//     rst        in   asynchronous reset, active low
//     rx_valid   in   byte offered on rx_data
//     rx_data    in   [7:0] offered byte
//     rx_ready   out  loader accepts a byte (low only in DONE)
//     reload     in   single-cycle pulse, DONE -> SYNC
//     mem_we     out  one-cycle RAM write strobe
//     mem_addr   out  [3:0] RAM write address
//     mem_wdata  out  [7:0] RAM write data
//     cpu_hold   out  keeps the CPU in reset (low only in DONE)
//     done       out  program loaded and accepted
//     err        out  last frame rejected
// ---------------------------------------------------------------------------
module sap1_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MEM_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    input  logic       reload,
    output logic       mem_we,
    output logic [3:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_hold,
    output logic       done,
    output logic       err
);

    localparam logic [7:0] DEPTH_B = MEM_DEPTH[7:0];

    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_DONE  = 3'd4,
`ifdef LOADER_CHECKSUM_EN
        ST_ERROR = 3'd5,
        ST_CHECK = 3'd3
`else
        ST_ERROR = 3'd5
`endif
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic        acc_s;         // byte transfer on this edge
    logic [3:0]  idx_r;         // address of the next data byte
    logic [3:0]  last_r;        // N-1, index of the final data byte
    logic        mem_we_r;
    logic [3:0]  mem_addr_r;
    logic [7:0]  mem_wdata_r;
    logic        rx_ready_r;
    logic        cpu_hold_r;
    logic        done_r;
    logic        err_r;
    logic        rx_ready_s;
    logic        cpu_hold_s;
    logic        done_s;
    logic        err_s;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum_r;

    // Running checksum: modulo-256 sum, carry discarded.
    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction
`endif

    // A count byte is valid when it addresses at least one and at most MEM_DEPTH words.
    function automatic logic count_ok(input logic [7:0] n);
        return (n != 8'd0) && (n <= DEPTH_B);
    endfunction

    assign acc_s     = rx_valid & rx_ready_r;
    assign rx_ready  = rx_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign cpu_hold  = cpu_hold_r;
    assign done      = done_r;
    assign err       = err_r;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_SYNC;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_SYNC: begin
                if (acc_s && (rx_data == SYNC_BYTE)) begin
                    state_nxt_s = ST_COUNT;
                end else begin
                    state_nxt_s = ST_SYNC;
                end
            end
            ST_COUNT: begin
                if (acc_s) begin
                    if (count_ok(rx_data)) begin
                        state_nxt_s = ST_DATA;
                    end else begin
                        state_nxt_s = ST_ERROR;
                    end
                end else begin
                    state_nxt_s = ST_COUNT;
                end
            end
            ST_DATA: begin
                // SYNC_BYTE is plain data here; only the index ends the phase.
                if (acc_s && (idx_r == last_r)) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nxt_s = ST_CHECK;
`else
                    state_nxt_s = ST_DONE;
`endif
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (acc_s) begin
                    if (rx_data == sum_r) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_ERROR;
                    end
                end else begin
                    state_nxt_s = ST_CHECK;
                end
            end
`endif
            ST_DONE: begin
                if (reload) begin
                    state_nxt_s = ST_SYNC;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_ERROR: begin
                if (acc_s && (rx_data == SYNC_BYTE)) begin
                    state_nxt_s = ST_COUNT;
                end else begin
                    state_nxt_s = ST_ERROR;
                end
            end
            default: begin
                state_nxt_s = ST_SYNC;
            end
        endcase
    end

    // Output decode from the next state, so the status outputs can be registered
    // without lagging the state register.
    always_comb begin
        rx_ready_s = 1'b1;
        cpu_hold_s = 1'b1;
        done_s     = 1'b0;
        err_s      = 1'b0;
        case (state_nxt_s)
            ST_DONE: begin
                rx_ready_s = 1'b0;
                cpu_hold_s = 1'b0;
                done_s     = 1'b1;
                err_s      = 1'b0;
            end
            ST_ERROR: begin
                rx_ready_s = 1'b1;
                cpu_hold_s = 1'b1;
                done_s     = 1'b0;
                err_s      = 1'b1;
            end
            default: begin
                rx_ready_s = 1'b1;
                cpu_hold_s = 1'b1;
                done_s     = 1'b0;
                err_s      = 1'b0;
            end
        endcase
    end

    // Status output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_ready_r <= 1'b1;
            cpu_hold_r <= 1'b1;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            rx_ready_r <= rx_ready_s;
            cpu_hold_r <= cpu_hold_s;
            done_r     <= done_s;
            err_r      <= err_s;
        end
    end

    // Frame datapath: index, length, checksum and the RAM write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r       <= 4'd0;
            last_r      <= 4'd0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 4'd0;
            mem_wdata_r <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
            sum_r       <= 8'd0;
`endif
        end else begin
            mem_we_r <= 1'b0;
            if (acc_s && (state_r == ST_COUNT)) begin
                // N=16 wraps to 0 in four bits, so N-1 still yields 15.
                idx_r  <= 4'd0;
                last_r <= rx_data[3:0] - 4'd1;
`ifdef LOADER_CHECKSUM_EN
                sum_r  <= 8'd0;
`endif
            end else if (acc_s && (state_r == ST_DATA)) begin
                mem_we_r    <= 1'b1;
                mem_addr_r  <= idx_r;
                mem_wdata_r <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                sum_r       <= csum_add(sum_r, rx_data);
`endif
                // Hold at N-1 after the last byte rather than wrapping.
                if (idx_r != last_r) begin
                    idx_r <= idx_r + 4'd1;
                end else begin
                    idx_r <= idx_r;
                end
            end else begin
                idx_r <= idx_r;
            end
        end
    end

endmodule

// File: tb/tb_sap1_loader.sv
// ---------------------------------------------------------------------------
// tb_sap1_loader: self-checking bench for sap1_loader. Expected RAM writes
// are queued as each data byte is driven and popped by a write monitor.
// Follows the LOADER_CHECKSUM_EN build option of the design.
// ---------------------------------------------------------------------------
module tb_sap1_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       reload;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;
    int we_count = 0;
    logic [11:0] wq[$];
    logic [7:0]  payload[$];

    sap1_loader dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .reload    (reload),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        logic [11:0] e;
        if (rst === 1'b1 && mem_we === 1'b1) begin
            we_count++;
            if (wq.size() == 0) begin
                check_eq("unexpected_we", 32'd1, 32'd0);
            end else begin
                e = wq.pop_front();
                check_eq("wr_addr", 32'(mem_addr), 32'(e[11:8]));
                check_eq("wr_data", 32'(mem_wdata), 32'(e[7:0]));
            end
        end
    end

    // Offer one byte (after optional idle cycles) and hold it until accepted.
    // Called and returns at posedge+1.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int  n;
        bit  ok;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n  = 0;
        ok = 1'b0;
        while (n < 64 && !ok) begin
            @(negedge clk);
            if (rx_ready === 1'b1) ok = 1'b1;
            n++;
        end
        if (!ok) check_eq("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Send a complete frame with the bytes in payload.
    task automatic send_frame(input logic [7:0] cnt, input bit bad_sum, input int gapmax);
        logic [7:0] sum;
        sum = 8'd0;
        send_byte(8'hA5, 0);
        send_byte(cnt, 0);
        for (int i = 0; i < payload.size(); i++) begin
            wq.push_back({4'(i), payload[i]});
            sum = sum + payload[i];
            send_byte(payload[i], (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(bad_sum ? (sum - 8'd1) : sum, 0);
`else
        if (bad_sum) check_eq("bad_sum_unsupported", 32'd0, 32'd0);
`endif
    endtask

    // Wait (bounded) for done (sel=0) or err (sel=1).
    task automatic wait_flag(input string tag, input bit sel);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            if ((sel ? err : done) === 1'b1) ok = 1'b1;
        end
        check_eq(tag, 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        check_eq("reload_hold", 32'(cpu_hold), 32'd1);
        check_eq("reload_done", 32'(done), 32'd0);
        check_eq("reload_ready", 32'(rx_ready), 32'd1);
    endtask

    initial begin
        int we0;
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        reload   = 1'b0;
        #12;
        check_eq("rst_we", 32'(mem_we), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_wdata", 32'(mem_wdata), 32'd0);
        check_eq("rst_hold", 32'(cpu_hold), 32'd1);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_ready", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Junk before a frame is discarded; then a good 3-byte frame.
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        payload = '{8'h3E, 8'h1F, 8'hE0};
        send_frame(8'h03, 1'b0, 0);
        wait_flag("frame_a_done", 1'b0);
        check_eq("a_hold", 32'(cpu_hold), 32'd0);
        check_eq("a_err", 32'(err), 32'd0);
        check_eq("a_wq_empty", 32'(wq.size()), 32'd0);

        // In DONE the loader refuses bytes.
        we0 = we_count;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("done_ready", 32'(rx_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check_eq("done_no_we", 32'(we_count - we0), 32'd0);
        do_reload();

`ifdef LOADER_CHECKSUM_EN
        payload = '{8'h3E, 8'h1F, 8'hE0};
        send_frame(8'h03, 1'b1, 0);
        wait_flag("bad_sum_err", 1'b1);
        check_eq("bad_hold", 32'(cpu_hold), 32'd1);
        check_eq("bad_done", 32'(done), 32'd0);
        check_eq("bad_wq_empty", 32'(wq.size()), 32'd0);
        payload = '{8'hFF};
        send_frame(8'h01, 1'b0, 0);
        wait_flag("recover_done", 1'b0);
        check_eq("recover_err", 32'(err), 32'd0);
`else
        payload = '{8'h7F};
        send_frame(8'h01, 1'b0, 0);
        wait_flag("nosum_done", 1'b0);
        check_eq("nosum_err", 32'(err), 32'd0);
`endif
        do_reload();

        // Zero count -> ERROR without writes.
        we0 = we_count;
        send_byte(8'h00, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        wait_flag("cnt0_err", 1'b1);
        check_eq("cnt0_no_we", 32'(we_count - we0), 32'd0);
        check_eq("cnt0_hold", 32'(cpu_hold), 32'd1);
        check_eq("cnt0_done", 32'(done), 32'd0);

        // SYNC from ERROR clears err; count 17 is rejected.
        send_byte(8'hA5, 0);
        check_eq("err_cleared", 32'(err), 32'd0);
        send_byte(8'h11, 0);
        wait_flag("cnt17_err", 1'b1);
        check_eq("cnt17_no_we", 32'(we_count - we0), 32'd0);

        // Count 16 loads addresses 0..15.
        payload.delete();
        for (int i = 0; i < 16; i++) payload.push_back(8'(i * 7 + 1));
        send_frame(8'h10, 1'b0, 0);
        wait_flag("cnt16_done", 1'b0);
        check_eq("cnt16_we", 32'(we_count - we0), 32'd16);
        check_eq("cnt16_wq_empty", 32'(wq.size()), 32'd0);
        do_reload();

        // Idle gaps and SYNC_BYTE as data.
        we0 = we_count;
        payload = '{8'hA5, 8'h00, 8'hA5};
        send_frame(8'h03, 1'b0, 2);
        wait_flag("bubble_done", 1'b0);
        check_eq("bubble_we", 32'(we_count - we0), 32'd3);
        check_eq("bubble_wq_empty", 32'(wq.size()), 32'd0);
        do_reload();

        // Reset in the middle of a frame.
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        wq.push_back({4'd0, 8'h11});
        send_byte(8'h11, 0);
        wq.push_back({4'd1, 8'h22});
        send_byte(8'h22, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_we", 32'(mem_we), 32'd0);
        check_eq("arst_addr", 32'(mem_addr), 32'd0);
        check_eq("arst_wdata", 32'(mem_wdata), 32'd0);
        check_eq("arst_hold", 32'(cpu_hold), 32'd1);
        check_eq("arst_done", 32'(done), 32'd0);
        check_eq("arst_err", 32'(err), 32'd0);
        check_eq("arst_ready", 32'(rx_ready), 32'd1);
        check_eq("arst_wq_empty", 32'(wq.size()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        payload = '{8'h01, 8'h02, 8'h03};
        send_frame(8'h03, 1'b0, 0);
        wait_flag("post_rst_done", 1'b0);
        check_eq("post_rst_wq_empty", 32'(wq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
